uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  UART receiver with buffered byte output, upstream of the SoC serial input path.
//  Takes the raw FTDI TX pin (ftdi_txd) and deserialises 8N1 frames.
//  Queues received bytes in a FWFT FIFO and presents them on a valid/ready stream.
//  Lets host->SoC traffic (console, program loading) survive CPU stalls without byte loss.
// PARAMETERS
//  CLK_FREQ    25_000_000  system clock frequency in Hz
//  BAUDRATE    115200      line rate in baud
//  FIFO_DEPTH  16          byte entries; power of two, >= 2
//  (derived) DIV = (CLK_FREQ + BAUDRATE/2) / BAUDRATE = 217 cycles/bit; HALF = DIV/2 = 108
// PORTS
//  clk_i         in   1                   system clock
//  rst_i         in   1                   synchronous reset, active-high
//  rx_i          in   1                   asynchronous serial line, idle high
//  data_o        out  8                   FIFO head byte; valid only when valid_o=1
//  valid_o       out  1                   FIFO non-empty
//  ready_i       in   1                   consumer accepts head byte when valid_o & ready_i
//  count_o       out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  frame_err_o   out  1                   1-cycle pulse: stop bit sampled low, byte discarded
//  overrun_o     out  1                   1-cycle pulse: good byte dropped because FIFO full
// BEHAVIOUR
//  Interface: one clock, clk_i; reset rst_i synchronous, active-high.
//  Reset: FSM=IDLE, counters=0, FIFO empty.
//   valid_o=0, count_o=0, frame_err_o=0, overrun_o=0, data_o=0.
//   Sync flops preset to 1 (idle line).
//  rx_i passes a 2-FF synchronizer; FSM sees rx_s, 2 cycles behind the pin.
//  FSM states:
//   IDLE : rx_s==0 -> START, bit counter cleared.
//   START: wait HALF cycles, then resample.
//          rx_s==1 -> IDLE (glitch, nothing reported); rx_s==0 -> DATA, bit index 0.
//   DATA : every DIV cycles sample rx_s into shift register, LSB first.
//          After bit 7 is sampled -> STOP.
//   STOP : after DIV cycles sample rx_s.
//          1 -> push byte; 0 -> pulse frame_err_o, no push. Both -> IDLE.
//  Next frame: start detection resumes the cycle after STOP sampling.
//   Back-to-back frames with zero idle bits are received.
//  FIFO: first-word-fall-through; data_o/valid_o reflect the head combinationally from FIFO regs.
//  Push latency: byte visible (valid_o=1) the cycle after the stop-bit sample.
//  Pop: when valid_o & ready_i at a clock edge; data_o changes to the next entry or valid_o drops.
//  Full & push & no pop: byte dropped, overrun_o pulses, FIFO contents unchanged.
//  Full & push & pop same cycle: both occur, count_o stays FIFO_DEPTH, no overrun.
//  Empty & push & ready_i=1: no bypass; byte becomes valid next cycle, no pop that cycle.
//  Pointers wrap modulo FIFO_DEPTH; count_o range 0..FIFO_DEPTH.
//  ready_i while valid_o=0 is ignored.
//  Reset mid-frame: frame abandoned, FIFO flushed, no pulses.
//   Receiver re-arms and waits for a fresh falling edge.
// TESTING
//  1. Send 0x55 at 115200 (DIV=217), ready_i=1 -> one valid_o cycle, data_o=0x55, no error pulses.
//  2. Frame 0xA3 with stop bit held low -> frame_err_o one pulse; valid_o stays 0, count_o=0.
//  3. rx_i low for 50 cycles then high -> FSM returns to IDLE; no byte, no pulse.
//  4. ready_i=0, send 0x00..0x10 (17 bytes) -> count_o=16, overrun_o pulses on byte 0x10.
//     Then drain: data_o reads 0x00..0x0F in order.
//  5. FIFO full, ready_i=1 asserted exactly on the push cycle of byte 0x77 -> no overrun.
//     count_o stays 16; 0x77 is read last.
//  6. Assert rst_i during data bit 4, release, send 0x3C -> only 0x3C received, count_o=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with a valid/ready output.
// Frame errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 25_000_000,
   parameter int BAUDRATE   = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rx_i,
   output logic [7:0]                    data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          frame_err_o,
   output logic                          overrun_o
);
   localparam int DIV  = (CLK_FREQ + BAUDRATE/2) / BAUDRATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int NW   = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            rx_meta_q, rx_s_q;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic            push, pop, full, wr_en;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         IDLE: if (!rx_s_q) begin
            state_d = START;
            cnt_d   = '0;
         end
         START: if (cnt_q == CW'(HALF - 1)) begin
            cnt_d = '0;
            bit_d = '0;
            state_d = rx_s_q ? IDLE : DATA;
         end else cnt_d = cnt_q + CW'(1);
         DATA: if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
         end else cnt_d = cnt_q + CW'(1);
         STOP: if (cnt_q == CW'(DIV - 1)) begin
            cnt_d       = '0;
            state_d     = IDLE;
            push        = rx_s_q;
            frame_err_d = !rx_s_q;
         end else cnt_d = cnt_q + CW'(1);
         default: state_d = IDLE;
      endcase
   end

   // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
   always_comb begin
      pop       = (count_q != '0) && ready_i;
      full      = (count_q == NW'(FIFO_DEPTH));
      wr_en     = push && (!full || pop);
      overrun_d = push && full && !pop;
      wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d   = count_q + NW'(wr_en) - NW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         rx_meta_q   <= rx_i;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i) mem_q[wr_ptr_q] <= shift_q;
   end

   assign valid_o     = (count_q != '0);
   assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
   assign count_o     = count_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frame driver, byte scoreboard and pulse counters.
module tb_uart_rx_fifo;
   localparam int CLK_FREQ = 25_000_000;
   localparam int BAUD     = 115200;
   localparam int DEPTH    = 16;
   localparam int DIV      = (CLK_FREQ + BAUD/2) / BAUD;
   localparam int HALF     = DIV / 2;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b1;
   logic                     rx_i = 1'b1;
   logic                     ready_i = 1'b0;
   logic [7:0]               data_o;
   logic                     valid_o, frame_err_o, overrun_o;
   logic [$clog2(DEPTH):0]   count_o;

   int total = 0, bad = 0;
   int ferr_n = 0, ovr_n = 0, vld_n = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_bytes;
      int         exp_ferr;
   } vec_t;
   vec_t vecs [5];

   uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready_i), .count_o(count_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
   );

   always #20 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_i) begin
         if (frame_err_o) ferr_n++;
         if (overrun_o) ovr_n++;
         if (valid_o) vld_n++;
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL pop_unexpected: got 0x%0h expected no byte", data_o);
            end else chk("pop_data", int'(data_o), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input logic exp_push);
      if (exp_push) exp_q.push_back(d);
      @(posedge clk); #1; rx_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         repeat (DIV) @(posedge clk);
         #1;
         rx_i = (i < 8) ? d[i] : ((i == 8) ? stop : 1'b1);
      end
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ready_i = 1'b1;
      for (int n = 0; n < 200 && count_o != 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("drain_count", int'(count_o), 0);
      chk("drain_queue_left", exp_q.size(), 0);
   endtask

   initial begin
      int f0, v0, o0;
      vecs[0] = '{8'h55, 1'b1, 1, 0};
      vecs[1] = '{8'hA3, 1'b0, 0, 1};
      vecs[2] = '{8'h00, 1'b1, 1, 0};
      vecs[3] = '{8'hFF, 1'b1, 1, 0};
      vecs[4] = '{8'h81, 1'b1, 1, 0};

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_count", int'(count_o), 0);
      chk("rst_data", int'(data_o), 0);
      chk("rst_ferr", int'(frame_err_o), 0);
      chk("rst_ovr", int'(overrun_o), 0);
      @(posedge clk); #1; rst_i = 1'b0;
      repeat (5) @(posedge clk); #1;

      ready_i = 1'b1;
      foreach (vecs[i]) begin
         f0 = ferr_n; v0 = vld_n; o0 = ovr_n;
         send_frame(vecs[i].data, vecs[i].stop, 40, vecs[i].stop);
         repeat (DIV) @(posedge clk); #1;
         chk($sformatf("vec%0d_valid_cycles", i), vld_n - v0, vecs[i].exp_bytes);
         chk($sformatf("vec%0d_ferr", i), ferr_n - f0, vecs[i].exp_ferr);
         chk($sformatf("vec%0d_ovr", i), ovr_n - o0, 0);
         chk($sformatf("vec%0d_count", i), int'(count_o), 0);
      end
      chk("vec_queue_left", exp_q.size(), 0);

      // short low glitch on an idle line
      f0 = ferr_n; v0 = vld_n;
      rx_i = 1'b0;
      repeat (50) @(posedge clk); #1;
      rx_i = 1'b1;
      repeat (3 * DIV) @(posedge clk); #1;
      chk("glitch_valid", vld_n - v0, 0);
      chk("glitch_ferr", ferr_n - f0, 0);
      chk("glitch_count", int'(count_o), 0);

      // fill with near back-to-back frames, then overflow
      ready_i = 1'b0;
      o0 = ovr_n;
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0, 1'b1);
      repeat (5) @(posedge clk); #1;
      chk("fill_count", int'(count_o), 16);
      chk("fill_no_ovr", ovr_n - o0, 0);
      send_frame(8'h10, 1'b1, 20, 1'b0);
      chk("ovr_pulse", ovr_n - o0, 1);
      chk("ovr_count", int'(count_o), 16);
      chk("ovr_head", int'(data_o), 8'h00);

      // pop exactly on the push edge of 0x77 while full
      o0 = ovr_n;
      fork
         send_frame(8'h77, 1'b1, 20, 1'b1);
         begin
            @(posedge clk);
            repeat (2 + HALF + 9 * DIV) @(posedge clk);
            #1; ready_i = 1'b1;
            @(posedge clk);
            #1; ready_i = 1'b0;
            @(negedge clk);
            chk("simul_count", int'(count_o), 16);
         end
      join
      chk("simul_no_ovr", ovr_n - o0, 0);
      chk("simul_head", int'(data_o), 8'h01);
      drain();

      // reset in the middle of a frame with a byte already queued
      ready_i = 1'b0;
      send_frame(8'h11, 1'b1, 20, 1'b1);
      chk("pre_rst_count", int'(count_o), 1);
      f0 = ferr_n; o0 = ovr_n;
      @(posedge clk); #1; rx_i = 1'b0;
      repeat (5 * DIV) @(posedge clk); #1;
      rx_i = 1'b1;
      repeat (HALF) @(posedge clk); #1;
      rst_i = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst_i = 1'b0;
      exp_q.delete();
      repeat (2 * DIV) @(posedge clk); #1;
      chk("midrst_count", int'(count_o), 0);
      chk("midrst_valid", int'(valid_o), 0);
      chk("midrst_ferr", ferr_n - f0, 0);
      chk("midrst_ovr", ovr_n - o0, 0);
      send_frame(8'h3C, 1'b1, 20, 1'b1);
      chk("post_rst_count", int'(count_o), 1);
      chk("post_rst_data", int'(data_o), 8'h3C);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #10ms;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
